// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        HOLD  = 2'b10,
        FAULT = 2'b11
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time and holds it until the
// control FSM consumes it with a next pulse (optionally redirected).
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ack,
    input  logic            next,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            instr_valid,
    output logic            fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_next_q, pc_next_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;

    // State and output registers; reset is asynchronous so a mid-request abort is immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_next_q <= RESET_PC;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_next_q <= pc_next_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state logic; next/redirect/ack are only looked at in the state that owns them.
    always_comb begin
        state_d   = state_q;
        pc_next_d = pc_next_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    pc_d    = pc_next_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (next) begin
                    valid_d = 1'b0;
                    if (!redirect) begin
                        pc_next_d = pc_q + 32'd4;
                        state_d   = REQ;
                    end else if (is_word_aligned(redirect_pc)) begin
                        pc_next_d = redirect_pc;
                        state_d   = REQ;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            FAULT: begin
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_next_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit, plus hand sequences for reset and wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        fault;

    logic        w_rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_ack;
    logic        w_next;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_valid;
    logic        w_fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .next(next), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr(instr), .pc(pc), .instr_valid(instr_valid),
        .fault(fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .imem_ack(w_ack), .next(w_next), .redirect(1'b0),
        .redirect_pc(32'h0000_0000), .instr(w_instr), .pc(w_pc), .instr_valid(w_valid),
        .fault(w_fault)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        ack;
        logic        nxt;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_fault;
        logic        chk_addr;
        logic        chk_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [31:0] rdata, input logic ack, input logic nxt,
                       input logic redir, input logic [31:0] rpc, input logic e_req,
                       input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic e_fault, input logic chk_addr,
                       input logic chk_data);
        vec_t v;
        v.rdata = rdata; v.ack = ack; v.nxt = nxt; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_fault = e_fault; v.chk_addr = chk_addr; v.chk_data = chk_data;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] rdata, input logic ack, input logic nxt,
                         input logic redir, input logic [31:0] rpc);
        imem_rdata  = rdata;
        imem_ack    = ack;
        next        = nxt;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        w_rst_n = 1'b0;
        w_rdata = 32'h0; w_ack = 1'b0; w_next = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Each row: inputs applied during the cycle, expected outputs of that same cycle.
        //   rdata         ack   nxt   redir rpc            req   addr           vld   instr          pc             flt   cA    cD
        add(32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b0, 1'b1);
        add(32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b1, 1'b1);
        add(32'h0030_0293, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b1, 1'b1);
        add(32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0030_0293, 32'h0,         1'b0, 1'b0, 1'b1);
        add(32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0030_0293, 32'h0,         1'b0, 1'b0, 1'b1);
        add(32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0030_0293, 32'h0,         1'b0, 1'b1, 1'b1);
        add(32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0030_0293, 32'h0,         1'b0, 1'b1, 1'b1);
        add(32'h0,         1'b0, 1'b1, 1'b1, 32'h3,         1'b1, 32'h4,         1'b0, 32'h0030_0293, 32'h0,         1'b0, 1'b1, 1'b1);
        add(32'h0040_0313, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0030_0293, 32'h0,         1'b0, 1'b1, 1'b1);
        add(32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0040_0313, 32'h4,         1'b0, 1'b0, 1'b1);
        add(32'h0050_0393, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b0, 32'h0040_0313, 32'h4,         1'b0, 1'b1, 1'b1);
        add(32'h0,         1'b0, 1'b1, 1'b1, 32'h100,       1'b0, 32'h0,         1'b1, 32'h0050_0393, 32'h8,         1'b0, 1'b0, 1'b1);
        add(32'h0060_0413, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0050_0393, 32'h8,         1'b0, 1'b1, 1'b1);
        add(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h200,       1'b0, 32'h0,         1'b1, 32'h0060_0413, 32'h100,       1'b0, 1'b0, 1'b1);
        add(32'h0,         1'b0, 1'b1, 1'b1, 32'h102,       1'b0, 32'h0,         1'b1, 32'h0060_0413, 32'h100,       1'b0, 1'b0, 1'b1);
        add(32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0);

        step();
        step();
        chk("reset_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset_req",   {31'd0, imem_req}, 32'd0);
        chk("reset_instr", instr, 32'h0000_0013);
        chk("reset_fault", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rdata, vecs[i].ack, vecs[i].nxt, vecs[i].redir, vecs[i].rpc);
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_fault", i), {31'd0, fault}, {31'd0, vecs[i].e_fault});
            if (vecs[i].chk_addr) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
                chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            end
            step();
        end

        // FAULT is sticky: stimulus of every kind must not wake it up.
        for (int k = 0; k < 10; k++) begin
            drive(32'h1234_5678, k[0], 1'b1, k[1], 32'h0000_0040);
            #1;
            chk($sformatf("fault_hold%0d_req", k), {31'd0, imem_req}, 32'd0);
            chk($sformatf("fault_hold%0d_flag", k), {31'd0, fault}, 32'd1);
            chk($sformatf("fault_hold%0d_valid", k), {31'd0, instr_valid}, 32'd0);
            step();
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset clears the fault asynchronously.
        #2 rst_n = 1'b0;
        #1;
        chk("fault_clear", {31'd0, fault}, 32'd0);
        chk("fault_clear_instr", instr, 32'h0000_0013);
        chk("fault_clear_pc", pc, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        #1;
        chk("rq_req", {31'd0, imem_req}, 32'd1);
        chk("rq_addr", imem_addr, 32'h0);
        // Abort mid-request, then stray ack/next while in IDLE.
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req", {31'd0, imem_req}, 32'd0);
        step();
        rst_n = 1'b1;
        drive(32'hBAD0_BAD0, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);
        step();
        drive(32'h0070_0493, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, 32'h0);
        chk("refetch_instr", instr, 32'h0000_0013);
        chk("refetch_valid", {31'd0, instr_valid}, 32'd0);
        step();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("refetch_got", instr, 32'h0070_0493);
        chk("refetch_pc", pc, 32'h0);
        chk("refetch_v", {31'd0, instr_valid}, 32'd1);

        // Sequential PC wraps from the top of the address space.
        w_rst_n = 1'b1;
        step();
        #1;
        chk("wrap_req0", {31'd0, w_req}, 32'd1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        w_ack = 1'b1; w_rdata = 32'h0000_0013;
        step();
        w_ack = 1'b0; w_next = 1'b1;
        #1;
        chk("wrap_pc0", w_pc, 32'hFFFF_FFFC);
        step();
        w_next = 1'b0;
        #1;
        chk("wrap_req1", {31'd0, w_req}, 32'd1);
        chk("wrap_addr1", w_addr, 32'h0000_0000);
        w_ack = 1'b1; w_rdata = 32'h0010_0093;
        step();
        w_ack = 1'b0;
        #1;
        chk("wrap_pc1", w_pc, 32'h0000_0000);
        chk("wrap_instr1", w_instr, 32'h0010_0093);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address.
REQ-006 imem_rdata  input  32  instruction word; valid only in the cycle imem_ack=1.
REQ-007 imem_ack  input  1  memory completion strobe.
REQ-008 next  input  1  one-cycle pulse from control FSM: current instruction consumed, fetch next.
REQ-009 redirect  input  1  qualifies next: take redirect_pc instead of pc+4.
REQ-010 redirect_pc  input  32  branch/jump target.
REQ-011 instr  output  32  registered instruction word, drives decoder instr input.
REQ-012 pc  output  32  address of the word currently held in instr.
REQ-013 instr_valid  output  1  instr/pc are valid and stable.
REQ-014 fault  output  1  sticky misaligned-target flag.

Function
REQ-015 FSM states: IDLE, REQ, HOLD, FAULT.
REQ-016 IDLE: outputs idle; unconditional transition to REQ next cycle.
REQ-017 REQ: imem_req=1, imem_addr=pc_next, both held stable until imem_ack; ack -> instr<=imem_rdata, pc<=pc_next, go HOLD.
REQ-018 Zero-wait memory: ack in first REQ cycle gives instr_valid=1 on the following cycle (minimum latency 1 cycle from REQ entry).
REQ-019 HOLD: instr_valid=1, imem_req=0; instr and pc unchanged until next.
REQ-020 HOLD with next=1, redirect=0: pc_next<=pc+4 (32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000), go REQ, instr_valid drops next cycle.
REQ-021 HOLD with next=1, redirect=1, redirect_pc[1:0]==2'b00: pc_next<=redirect_pc, go REQ.
REQ-022 HOLD with next=1, redirect=1, redirect_pc[1:0]!=2'b00: go FAULT, no memory request issued.
REQ-023 FAULT: fault=1, instr_valid=0, imem_req=0; exit only via reset.
REQ-024 next or redirect outside HOLD: ignored, no state change.
REQ-025 imem_ack outside REQ: ignored; imem_rdata not captured.
REQ-026 redirect without next: ignored in all states.
REQ-027 imem_addr=pc_next whenever imem_req=1; value otherwise don't-care but driven (no X).

Reset
REQ-028 rst_n low: state<=IDLE, pc_next<=RESET_PC, pc<=RESET_PC, instr<=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fault=0, asynchronously.
REQ-029 Reset asserted mid-REQ aborts the request; a late imem_ack after release is ignored because FSM is in IDLE.
REQ-030 First request after reset release addresses RESET_PC.

Structure
REQ-031 Shared package riscv_pkg holds fetch_state_t enum, NOP_INSTR constant (32'h0000_0013), XLEN=32.
REQ-032 Single flat module; no sub-module; outputs registered except imem_req/imem_addr (decoded from state).

Verification
REQ-033 Reset release, ack 1 cycle after req, rdata=32'h0030_0293 -> imem_addr=0x0, then instr=0x00300293, pc=0x0, instr_valid=1.
REQ-034 HOLD, next pulse, ack after 3 wait cycles -> imem_addr=0x4 held stable 4 cycles, instr_valid=0 throughout, then pc=0x4.
REQ-035 HOLD at pc=0x8, next+redirect, redirect_pc=0x100 -> imem_addr=0x100, pc=0x100 after ack.
REQ-036 next+redirect with redirect_pc=0x102 -> FAULT, fault=1, imem_req stays 0 for 10 cycles, cleared only by rst_n.
REQ-037 RESET_PC=0xFFFF_FFFC, fetch then next -> imem_addr=0x0000_0000 (wrap).
REQ-038 rst_n pulsed low mid-REQ, stray ack plus next pulse in IDLE -> instr=0x00000013, instr_valid=0, refetch from RESET_PC.
